// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: decodes RV32 R-type and I-type ALU instructions into ALU
// control, register-write, operand-select and immediate fields. The result is
// held in a one-entry valid/ready output stage between fetch and execute.
//
// Optional feature macro: DECODE_MUL_EN
//   defined   -> MUL (funct7=1, funct3=0) is decoded and holds the stage for
//                MUL_LATENCY cycles before it is presented.
//   undefined -> every funct7=1 encoding is illegal; the stage is latency-1.
//
// Parameters:
//   ALU_CTRL_W  - width of alu_control (>= 4)
//   MUL_LATENCY - cycles from MUL acceptance to out_valid (>= 2)
//
// Ports:
//   clk, rst_n        - clock (rising edge), async active-low reset
//   flush             - synchronous flush; drops held/pending work
//   in_valid/in_ready - input handshake; instr is the RV32 word
//   out_valid/out_ready - output handshake toward execute
//   alu_control, regwrite_control, alusrc_imm, imm, rd, rs1, rs2, illegal
//                     - registered decoded payload
module decode_ctrl_stage #(
  parameter int unsigned ALU_CTRL_W  = 4,
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  regwrite_control,
  output logic                  alusrc_imm,
  output logic [31:0]           imm,
  output logic [4:0]            rd,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic                  illegal
);

  // Parameter sanity checks at elaboration time
  if (ALU_CTRL_W < 4) begin : g_bad_alu_w
    $error("decode_ctrl_stage: ALU_CTRL_W must be at least 4");
  end
  if (MUL_LATENCY < 2) begin : g_bad_mul_lat
    $error("decode_ctrl_stage: MUL_LATENCY must be at least 2");
  end

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'd0;
  localparam logic [6:0] F7_ALT  = 7'd32;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;

`ifdef DECODE_MUL_EN
  localparam logic [6:0]  F7_MUL = 7'd1;
  localparam logic [3:0]  OP_MUL = 4'b0110;
  localparam int unsigned CNT_W  = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
`endif

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_MUL   = 2'd2
  } state_t;

  state_t state;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        dec_legal;
  logic        dec_shift;
  logic        dec_src;
  logic [3:0]  dec_code;
  logic [31:0] dec_imm;
  logic        accept;

`ifdef DECODE_MUL_EN
  logic             dec_mul;
  logic [CNT_W-1:0] cnt;
`endif

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // ALU code for the funct7=0 flavour of each funct3
  function automatic logic [3:0] base_code(input logic [2:0] f3);
    case (f3)
      3'd0:    base_code = OP_ADD;
      3'd1:    base_code = OP_SLL;
      3'd2:    base_code = OP_SLT;
      3'd3:    base_code = OP_SLTU;
      3'd4:    base_code = OP_XOR;
      3'd5:    base_code = OP_SRL;
      3'd6:    base_code = OP_OR;
      default: base_code = OP_AND;
    endcase
  endfunction

  // Instruction decode; illegal encodings force zeroed control fields
  always_comb begin
    dec_legal = 1'b0;
    dec_shift = 1'b0;
    dec_src   = 1'b0;
    dec_code  = OP_AND;
    dec_imm   = 32'd0;
`ifdef DECODE_MUL_EN
    dec_mul   = 1'b0;
`endif
    case (opcode)
      OPC_R: begin
        if (funct7 == F7_BASE) begin
          dec_legal = 1'b1;
          dec_code  = base_code(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'd0) begin
          dec_legal = 1'b1;
          dec_code  = OP_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'd5) begin
          dec_legal = 1'b1;
          dec_code  = OP_SRA;
        end
`ifdef DECODE_MUL_EN
        else if (funct7 == F7_MUL && funct3 == 3'd0) begin
          dec_legal = 1'b1;
          dec_mul   = 1'b1;
          dec_code  = OP_MUL;
        end
`endif
      end
      OPC_I: begin
        // Only shifts carry funct7; other I-type ops ignore it
        dec_shift = (funct3 == 3'd1) || (funct3 == 3'd5);
        if (funct3 == 3'd1) begin
          dec_legal = (funct7 == F7_BASE);
        end else if (funct3 == 3'd5) begin
          dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        end else begin
          dec_legal = 1'b1;
        end
        dec_code = (funct3 == 3'd5 && funct7 == F7_ALT) ? OP_SRA : base_code(funct3);
        if (dec_legal) begin
          dec_src = 1'b1;
          dec_imm = dec_shift ? {27'd0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
        end
      end
      default: ;
    endcase
    if (!dec_legal) begin
      dec_code = OP_AND;
    end
  end

  assign in_ready  = !flush && (state == ST_EMPTY || (state == ST_FULL && out_ready));
  assign out_valid = (state == ST_FULL);
  assign accept    = in_valid && in_ready;

  // Stage FSM and payload register; flush overrides everything but reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_EMPTY;
      alu_control      <= '0;
      regwrite_control <= 1'b0;
      alusrc_imm       <= 1'b0;
      imm              <= 32'd0;
      rd               <= 5'd0;
      rs1              <= 5'd0;
      rs2              <= 5'd0;
      illegal          <= 1'b0;
`ifdef DECODE_MUL_EN
      cnt              <= '0;
`endif
    end else if (flush) begin
      state            <= ST_EMPTY;
      alu_control      <= '0;
      regwrite_control <= 1'b0;
      alusrc_imm       <= 1'b0;
      imm              <= 32'd0;
      rd               <= 5'd0;
      rs1              <= 5'd0;
      rs2              <= 5'd0;
      illegal          <= 1'b0;
`ifdef DECODE_MUL_EN
      cnt              <= '0;
`endif
    end else if (accept) begin
      alu_control      <= ALU_CTRL_W'(dec_code);
      regwrite_control <= dec_legal;
      alusrc_imm       <= dec_src;
      imm              <= dec_imm;
      rd               <= instr[11:7];
      rs1              <= instr[19:15];
      rs2              <= instr[24:20];
      illegal          <= !dec_legal;
`ifdef DECODE_MUL_EN
      // MUL waits in ST_MUL; counter reaches 0 one cycle before presentation
      state            <= dec_mul ? ST_MUL : ST_FULL;
      cnt              <= dec_mul ? CNT_W'(MUL_LATENCY - 2) : '0;
`else
      state            <= ST_FULL;
`endif
    end else begin
      case (state)
        ST_FULL: begin
          if (out_ready) begin
            state <= ST_EMPTY;
          end
        end
`ifdef DECODE_MUL_EN
        ST_MUL: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= ST_FULL;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Scoreboarded bench for decode_ctrl_stage: expected payloads are queued on
// input acceptance and compared by an independent output monitor.
module tb_decode_ctrl_stage;

  localparam int unsigned LAT = 4;

  typedef struct packed {
    logic [3:0]  alu;
    logic        rw;
    logic        src;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ill;
  } exp_t;

  localparam logic [31:0] I_ADD      = 32'h002081B3;
  localparam logic [31:0] I_ADDI     = 32'hFFF00293;
  localparam logic [31:0] I_SRAI     = 32'h4032D313;
  localparam logic [31:0] I_SLTIU    = 32'h7FF13593;
  localparam logic [31:0] I_SLLI_BAD = 32'h40309513;
  localparam logic [31:0] I_MULH     = 32'h02209633;
  localparam logic [31:0] I_MUL      = 32'h022083B3;
  localparam logic [31:0] I_SUB      = 32'h40208433;
  localparam logic [31:0] I_XOR      = 32'h0041C4B3;
  localparam logic [31:0] I_BAD      = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_control;
  logic        regwrite_control;
  logic        alusrc_imm;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        illegal;

  exp_t  sb[$];
  string sb_name[$];
  exp_t  cur_exp;
  string cur_name;
  int    errors = 0;
  int    checks = 0;

  decode_ctrl_stage #(.ALU_CTRL_W(4), .MUL_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_control(alu_control), .regwrite_control(regwrite_control),
    .alusrc_imm(alusrc_imm), .imm(imm),
    .rd(rd), .rs1(rs1), .rs2(rs2), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic exp_t ok_e(input logic [3:0] alu, input logic src, input logic [31:0] im,
                                input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    exp_t e;
    e.alu = alu; e.rw = 1'b1; e.src = src; e.imm = im;
    e.rd = d; e.rs1 = s1; e.rs2 = s2; e.ill = 1'b0;
    return e;
  endfunction

  function automatic exp_t bad_e(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    exp_t e;
    e.alu = 4'd0; e.rw = 1'b0; e.src = 1'b0; e.imm = 32'd0;
    e.rd = d; e.rs1 = s1; e.rs2 = s2; e.ill = 1'b1;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  // Acceptance tracker: queue the expected payload for each accepted word
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      sb.push_back(cur_exp);
      sb_name.push_back(cur_name);
    end
  end

  // Output monitor: compare each consumed payload with the queue head
  always @(negedge clk) begin : mon
    exp_t  got;
    exp_t  want;
    string nm;
    if (rst_n && out_valid && out_ready) begin
      got = {alu_control, regwrite_control, alusrc_imm, imm, rd, rs1, rs2, illegal};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got alu=%h rd=%0d ill=%b with nothing expected",
                 got.alu, got.rd, got.ill);
      end else begin
        want = sb.pop_front();
        nm   = sb_name.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL sb_%s: got alu=%h rw=%b src=%b imm=%h rd=%0d rs1=%0d rs2=%0d ill=%b expected alu=%h rw=%b src=%b imm=%h rd=%0d rs1=%0d rs2=%0d ill=%b",
                   nm, got.alu, got.rw, got.src, got.imm, got.rd, got.rs1, got.rs2, got.ill,
                   want.alu, want.rw, want.src, want.imm, want.rd, want.rs1, want.rs2, want.ill);
        end
      end
    end
  end

  // Present one word until accepted; returns at posedge+1 after acceptance
  task automatic send(input string nm, input logic [31:0] word, input exp_t e, output int waited);
    in_valid = 1'b1;
    instr    = word;
    cur_exp  = e;
    cur_name = nm;
    waited   = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!in_ready && waited < 50);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_%s: in_ready=0 after %0d cycles, expected acceptance", nm, waited);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  exp_t e_mul;
  int   w1;
  int   w2;
  int   wd;

  initial begin
`ifdef DECODE_MUL_EN
    e_mul = ok_e(4'b0110, 1'b0, 32'd0, 5'd7, 5'd1, 5'd2);
`else
    e_mul = bad_e(5'd7, 5'd1, 5'd2);
`endif
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    instr     = 32'd0;
    cur_exp   = '0;
    cur_name  = "none";

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_payload", 64'({alu_control, regwrite_control, alusrc_imm, imm, rd, rs1, rs2, illegal}), 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // ADD with one-cycle latency
    send("add", I_ADD, ok_e(4'b0010, 1'b0, 32'd0, 5'd3, 5'd1, 5'd2), w1);
    @(negedge clk);
    chk("add_latency", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    // Back-to-back I-type, in_ready never drops
    send("addi", I_ADDI, ok_e(4'b0010, 1'b1, 32'hFFFF_FFFF, 5'd5, 5'd0, 5'd31), w1);
    send("srai", I_SRAI, ok_e(4'b1000, 1'b1, 32'd3, 5'd6, 5'd5, 5'd3), w2);
    chk("b2b_wait_addi", 64'(w1), 64'd1);
    chk("b2b_wait_srai", 64'(w2), 64'd1);

    // Immediate boundary and funct7 legality corners
    send("sltiu", I_SLTIU, ok_e(4'b1010, 1'b1, 32'h0000_07FF, 5'd11, 5'd2, 5'd31), w1);
    send("slli_f7", I_SLLI_BAD, bad_e(5'd10, 5'd1, 5'd3), w1);
    send("mulh", I_MULH, bad_e(5'd12, 5'd1, 5'd2), w1);

    // MUL occupancy
    send("mul", I_MUL, e_mul, w1);
`ifdef DECODE_MUL_EN
    for (int k = 1; k < int'(LAT); k++) begin
      @(negedge clk);
      chk($sformatf("mul_busy_%0d", k), 64'({in_ready, out_valid}), 64'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("mul_done", 64'({in_ready, out_valid}), 64'd3);
`else
    @(negedge clk);
    chk("mul_illegal_latency", 64'({in_ready, out_valid}), 64'd3);
`endif
    @(posedge clk); #1;

    // Backpressure: SUB held stable while XOR waits
    send("sub", I_SUB, ok_e(4'b0100, 1'b0, 32'd0, 5'd8, 5'd1, 5'd2), w1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = I_XOR;
    cur_exp   = ok_e(4'b0111, 1'b0, 32'd0, 5'd9, 5'd3, 5'd4);
    cur_name  = "xor";
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold_%0d", k), 64'({out_valid, in_ready, alu_control, rd, rs1, rs2, imm}),
          64'({1'b1, 1'b0, 4'b0100, 5'd8, 5'd1, 5'd2, 32'd0}));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Unknown opcode, then flush two cycles into a MUL
    send("bad_opcode", I_BAD, bad_e(5'd0, 5'd0, 5'd0), w1);
    send("mul_flushed", I_MUL, e_mul, w1);
    out_ready = 1'b0;
    @(posedge clk); #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    instr    = I_ADD;
    cur_exp  = ok_e(4'b0010, 1'b0, 32'd0, 5'd3, 5'd1, 5'd2);
    cur_name = "add_during_flush";
    sb.delete();
    sb_name.delete();
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("post_flush_%0d", k), 64'({out_valid, in_ready}), 64'd1);
      @(posedge clk); #1;
    end

    // Asynchronous reset while work is held
    out_ready = 1'b0;
    send("mul_reset", I_MUL, e_mul, w1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", 64'({out_valid, in_ready, alu_control, regwrite_control, alusrc_imm, imm, rd, rs1, rs2, illegal}),
        64'({1'b0, 1'b1, 54'd0}));
    sb.delete();
    sb_name.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Drain anything outstanding
    wd = 0;
    while (sb.size() != 0 && wd < 20) begin
      @(negedge clk);
      wd++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
